// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the single-port RAM arbiter.
package ram_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 15;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned BE_W       = DATA_W / 8;

  typedef enum logic [1:0] {
    StIdle,
    StAck,
    StRmw
  } state_e;

endpackage

// File: rtl/byte_merge.sv
// Combinational byte merge: enabled bytes come from the new word, the rest from the old word.
module byte_merge
  import ram_arb_pkg::*;
(
  input  logic [DATA_W-1:0] i_old,
  input  logic [DATA_W-1:0] i_new,
  input  logic [BE_W-1:0]   i_be,
  output logic [DATA_W-1:0] o_merged
);

  // Replace each enabled byte lane
  always_comb begin
    o_merged = i_old;
    for (int i = 0; i < BE_W; i++) begin
      if (i_be[i]) begin
        o_merged[8*i +: 8] = i_new[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter between an instruction-fetch port (A, read-only) and a data port (B)
// sharing one 32-bit single-port RAM with registered read data. Partial B writes are done
// as read-modify-write.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  output logic              a_done,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic              b_we,
  input  logic [BE_W-1:0]   b_be,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_done,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout
);

  state_e              r_state;
  state_e              w_state_next;
  logic                r_last_b;   // last grant went to B
  logic                r_gnt_b;    // operation in flight belongs to B
  logic                w_any_req;
  logic                w_pick_b;
  logic                w_b_full;
  logic                w_b_part;
  logic                w_b_wr;
  logic [DATA_W-1:0]   w_merged;

  assign w_any_req = a_req | b_req;
  assign w_pick_b  = (a_req & b_req) ? ~r_last_b : b_req;
  assign w_b_full  = b_we & (b_be == 4'b1111);
  assign w_b_part  = b_we & (b_be != 4'b0000) & (b_be != 4'b1111);
  // be=0000 behaves as a read, so it is not a write completion
  assign w_b_wr    = b_we & (b_be != 4'b0000);

  byte_merge u_byte_merge (
    .i_old    (ram_dout),
    .i_new    (b_wdata),
    .i_be     (b_be),
    .o_merged (w_merged)
  );

  // State register and grant bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= StIdle;
      r_last_b <= 1'b1;
      r_gnt_b  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == StIdle && w_any_req) begin
        r_last_b <= w_pick_b;
        r_gnt_b  <= w_pick_b;
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_any_req) begin
          w_state_next = (w_pick_b && w_b_part) ? StRmw : StAck;
        end
      end
      StRmw:   w_state_next = StAck;
      StAck:   w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Output decode; reset forces every output low, including a pending RMW write
  always_comb begin
    ram_addr = '0;
    ram_din  = '0;
    ram_we   = 1'b0;
    a_done   = 1'b0;
    a_rdata  = '0;
    b_done   = 1'b0;
    b_rdata  = '0;
    if (!rst) begin
      unique case (r_state)
        StIdle: begin
          if (w_any_req) begin
            ram_addr = w_pick_b ? b_addr : a_addr;
            if (w_pick_b && w_b_full) begin
              ram_we  = 1'b1;
              ram_din = b_wdata;
            end
          end
        end
        StRmw: begin
          ram_addr = b_addr;
          ram_din  = w_merged;
          ram_we   = 1'b1;
        end
        StAck: begin
          if (r_gnt_b) begin
            b_done  = 1'b1;
            b_rdata = w_b_wr ? '0 : ram_dout;
          end else begin
            a_done  = 1'b1;
            a_rdata = ram_dout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model with a shadow memory.
module tb_ram_arbiter;

  localparam int AW    = 15;
  localparam int WORDS = 1 << AW;

  logic          clk;
  logic          rst;
  logic          a_req;
  logic [AW-1:0] a_addr;
  logic          a_done;
  logic [31:0]   a_rdata;
  logic          b_req;
  logic [AW-1:0] b_addr;
  logic          b_we;
  logic [3:0]    b_be;
  logic [31:0]   b_wdata;
  logic          b_done;
  logic [31:0]   b_rdata;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_din;
  logic          ram_we;
  logic [31:0]   ram_dout;

  ram_arbiter #(.ADDR_W(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .a_req    (a_req),
    .a_addr   (a_addr),
    .a_done   (a_done),
    .a_rdata  (a_rdata),
    .b_req    (b_req),
    .b_addr   (b_addr),
    .b_we     (b_we),
    .b_be     (b_be),
    .b_wdata  (b_wdata),
    .b_done   (b_done),
    .b_rdata  (b_rdata),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_we   (ram_we),
    .ram_dout (ram_dout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] init_word(input int i);
    case (i)
      32'h010: return 32'hDEADBEEF;
      32'h200: return 32'hAABBCCDD;
      32'h300: return 32'h0BADF00D;
      default: return (32'(i) * 32'h0100_0193) ^ 32'hC3A5_0F1E;
    endcase
  endfunction

  // Environment RAM: registered read, read-before-write
  logic [31:0] mem [WORDS];
  initial begin
    for (int i = 0; i < WORDS; i++) mem[i] = init_word(i);
    ram_dout = '0;
    forever begin
      @(posedge clk);
      ram_dout <= mem[ram_addr];
      if (ram_we) mem[ram_addr] <= ram_din;
    end
  end

  // Checking state
  int n_checks;
  int n_pass;
  int we_cnt;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, got, exp);
  endtask

  // Transaction-level model
  logic [31:0] sh_mem [WORDS];
  bit          m_busy;
  bit          m_last_b;
  bit          m_pick_b;
  int          m_kind;      // 0 read, 1 full write, 2 partial write, 3 empty write
  int          m_k;         // cycles since grant
  logic [AW-1:0] m_addr;
  logic [3:0]  m_be;
  logic [31:0] m_wdata;
  bit          m_done_a;
  bit          m_done_b;
  int          g_hist [$];

  task automatic model_cycle();
    logic [31:0] mg;
    logic [31:0] exp_rd;
    m_done_a = 1'b0;
    m_done_b = 1'b0;
    if (ram_we === 1'b1) we_cnt++;
    if (rst) begin
      chk("rst_ram_we", 32'(ram_we), 32'd0);
      chk("rst_done", {30'd0, a_done, b_done}, 32'd0);
      chk("rst_a_rdata", a_rdata, 32'd0);
      chk("rst_b_rdata", b_rdata, 32'd0);
      chk("rst_ram_addr", 32'(ram_addr), 32'd0);
      chk("rst_ram_din", ram_din, 32'd0);
      m_busy   = 1'b0;
      m_last_b = 1'b1;
      return;
    end
    if (!m_busy) begin
      chk("idle_done", {30'd0, a_done, b_done}, 32'd0);
      chk("idle_rdata", a_rdata | b_rdata, 32'd0);
      if (a_req || b_req) begin
        m_pick_b = (a_req && b_req) ? !m_last_b : b_req;
        m_last_b = m_pick_b;
        g_hist.push_back(int'(m_pick_b));
        m_addr  = m_pick_b ? b_addr : a_addr;
        m_be    = b_be;
        m_wdata = b_wdata;
        if (!m_pick_b || !b_we)      m_kind = 0;
        else if (b_be == 4'b1111)    m_kind = 1;
        else if (b_be == 4'b0000)    m_kind = 3;
        else                         m_kind = 2;
        chk("grant_addr", 32'(ram_addr), 32'(m_addr));
        chk("grant_we", 32'(ram_we), (m_kind == 1) ? 32'd1 : 32'd0);
        if (m_kind == 1) begin
          chk("grant_din", ram_din, m_wdata);
          sh_mem[m_addr] = m_wdata;
        end
        m_busy = 1'b1;
        m_k    = 0;
      end else begin
        chk("idle_we", 32'(ram_we), 32'd0);
      end
    end else begin
      m_k++;
      if (m_kind == 2 && m_k == 1) begin
        mg = sh_mem[m_addr];
        for (int i = 0; i < 4; i++) if (m_be[i]) mg[8*i +: 8] = m_wdata[8*i +: 8];
        chk("rmw_we", 32'(ram_we), 32'd1);
        chk("rmw_addr", 32'(ram_addr), 32'(m_addr));
        chk("rmw_din", ram_din, mg);
        chk("rmw_done", {30'd0, a_done, b_done}, 32'd0);
        sh_mem[m_addr] = mg;
      end else begin
        exp_rd = (m_kind == 0 || m_kind == 3) ? sh_mem[m_addr] : 32'd0;
        chk("ack_we", 32'(ram_we), 32'd0);
        chk("ack_done", {30'd0, a_done, b_done}, m_pick_b ? 32'd1 : 32'd2);
        chk("ack_a_rdata", a_rdata, m_pick_b ? 32'd0 : exp_rd);
        chk("ack_b_rdata", b_rdata, m_pick_b ? exp_rd : 32'd0);
        m_done_a = !m_pick_b;
        m_done_b = m_pick_b;
        m_busy   = 1'b0;
      end
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    model_cycle();
  endtask

  initial begin
    int sel;
    n_checks = 0;
    n_pass   = 0;
    we_cnt   = 0;
    m_busy   = 1'b0;
    m_last_b = 1'b1;
    for (int i = 0; i < WORDS; i++) sh_mem[i] = init_word(i);
    rst = 1'b1;
    a_req = 1'b1; a_addr = 15'h010;
    b_req = 1'b0; b_addr = '0; b_we = 1'b0; b_be = 4'b0000; b_wdata = '0;

    // Reset with a request pending: outputs must stay quiet
    repeat (3) begin adv(); settle(); end
    chk("lit_rst_addr", 32'(ram_addr), 32'd0);
    chk("lit_rst_adone", 32'(a_done), 32'd0);

    // A read of 0x0010
    adv(); rst = 1'b0; settle();
    chk("lit_a_grant_addr", 32'(ram_addr), 32'h10);
    adv(); settle();
    chk("lit_a_done", 32'(a_done), 32'd1);
    chk("lit_a_rdata", a_rdata, 32'hDEADBEEF);
    adv(); a_req = 1'b0; settle();

    // B full write then read back
    we_cnt = 0;
    adv(); b_req = 1'b1; b_we = 1'b1; b_be = 4'b1111; b_addr = 15'h100; b_wdata = 32'h12345678;
    settle();
    chk("lit_full_we", 32'(ram_we), 32'd1);
    adv(); settle();
    chk("lit_full_done", 32'(b_done), 32'd1);
    chk("lit_full_rdata", b_rdata, 32'd0);
    adv(); b_we = 1'b0; settle();
    adv(); settle();
    chk("lit_rd_back", b_rdata, 32'h12345678);
    chk("lit_we_once", 32'(we_cnt), 32'd1);
    adv(); b_req = 1'b0; settle();

    // Partial write be=0101 to 0x0200
    adv(); b_req = 1'b1; b_we = 1'b1; b_be = 4'b0101; b_addr = 15'h200; b_wdata = 32'h11223344;
    settle();
    chk("lit_part_grant_we", 32'(ram_we), 32'd0);
    adv(); settle();
    chk("lit_part_din", ram_din, 32'hAA22CC44);
    chk("lit_part_nodone", 32'(b_done), 32'd0);
    adv(); settle();
    chk("lit_part_done", 32'(b_done), 32'd1);
    adv(); b_req = 1'b0; a_req = 1'b1; a_addr = 15'h200; settle();
    adv(); settle();
    chk("lit_part_rd", a_rdata, 32'hAABBCCDD ^ 32'hAABBCCDD ^ 32'hAA22CC44);
    adv(); a_req = 1'b0; settle();

    // Continuous contention after reset: A, B, A, B
    adv(); rst = 1'b1; settle();
    adv(); rst = 1'b0; a_req = 1'b1; a_addr = 15'h010; b_req = 1'b1; b_we = 1'b0;
    b_addr = 15'h100; g_hist.delete(); settle();
    repeat (7) begin adv(); settle(); end
    chk("lit_rr_count", 32'(g_hist.size()), 32'd4);
    for (int k = 0; k < g_hist.size(); k++) chk("lit_rr_order", 32'(g_hist[k]), 32'(k % 2));
    adv(); a_req = 1'b0; b_req = 1'b0; settle();

    // Reset during RMW: no write, no done, FSM idle next cycle
    we_cnt = 0;
    adv(); b_req = 1'b1; b_we = 1'b1; b_be = 4'b0011; b_addr = 15'h300; b_wdata = 32'hFFFFFFFF;
    settle();
    adv(); rst = 1'b1; settle();
    chk("lit_rmwrst_we", 32'(ram_we), 32'd0);
    chk("lit_rmwrst_done", 32'(b_done), 32'd0);
    adv(); rst = 1'b0; b_req = 1'b0; a_req = 1'b1; a_addr = 15'h300; settle();
    chk("lit_rmwrst_idle", 32'(ram_addr), 32'h300);
    chk("lit_rmwrst_nodone", 32'(b_done), 32'd0);
    adv(); settle();
    chk("lit_rmwrst_mem", a_rdata, 32'h0BADF00D);
    chk("lit_rmwrst_nowe", 32'(we_cnt), 32'd0);
    adv(); a_req = 1'b0; settle();

    // Empty byte-enable write
    we_cnt = 0;
    adv(); b_req = 1'b1; b_we = 1'b1; b_be = 4'b0000; b_addr = 15'h040; settle();
    adv(); settle();
    chk("lit_be0_done", 32'(b_done), 32'd1);
    adv(); b_req = 1'b0; settle();
    chk("lit_be0_nowe", 32'(we_cnt), 32'd0);

    // Randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      adv();
      rst = ($urandom_range(0, 199) == 0);
      if (!a_req || m_done_a) begin
        a_req  = ($urandom_range(0, 2) != 0);
        a_addr = AW'($urandom_range(0, 31));
      end
      if (!b_req || m_done_b) begin
        b_req   = ($urandom_range(0, 2) != 0);
        b_we    = 1'($urandom_range(0, 1));
        sel     = $urandom_range(0, 3);
        b_be    = (sel == 0) ? 4'b0000 : (sel == 1) ? 4'b1111 : 4'($urandom_range(1, 14));
        b_addr  = AW'($urandom_range(0, 31));
        b_wdata = $urandom;
      end
      settle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
